inst_fetch: RTL and testbench

Instruction fetch stage of the multi-cycle MIPS core: owns the PC, issues instruction reads over a valid/ready memory port, captures the returned word in an instruction register, and presents it with its PC to the decode stage (`Control`), which consumes `opcode`/`r_opcode`. Branch and jump redirects from the execute stage retarget the PC and squash any in-flight or held fetch.

---
 rtl/inst_fetch_pkg.sv | 28 ++
 rtl/inst_fetch_pc_unit.sv | 35 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: reset PC, FSM encoding and the
// instruction field positions that decode also relies on.
package inst_fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_unit.sv
// Program counter: word-aligned register with sequential advance and
// redirect override; redirect always wins over advance.
module pc_unit
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_valid: pc_d = word_align(redirect_target);
            advance:        pc_d = pc_q + 32'd4;
            default:        pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= word_align(RESET_PC);
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: request/response FSM, discard flag for squashed
// responses, and the instruction register handed to decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    input  logic [31:0] inst_rdata,
    input  logic        inst_rdata_valid,
    output logic        inst_rdata_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] pc_next,
    output logic [5:0]  opcode,
    output logic [5:0]  r_opcode
);

    fetch_state_e state_q, state_d;
    logic         discard_q, discard_d;
    if_id_t       ir_q;
    logic         capture;
    logic         advance;
    logic [31:0]  pc;

    pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk             (clk),
        .rst             (rst),
        .advance         (advance),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc)
    );

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        capture   = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (inst_req_ready) begin
                    state_d   = WAIT;
                    discard_d = redirect_valid;
                end
            end
            WAIT: begin
                // A redirect poisons whatever response is still due.
                if (inst_rdata_valid) begin
                    if (redirect_valid || discard_q) begin
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                        capture = 1'b1;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = REQ;
                end else if (ir_ready) begin
                    state_d = REQ;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            ir_q      <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (capture) begin
                ir_q.ir <= inst_rdata;
                ir_q.pc <= pc;
            end
        end
    end

    assign inst_addr        = pc;
    assign inst_req_valid   = (state_q == REQ);
    assign inst_rdata_ready = (state_q == WAIT);
    assign ir_valid         = (state_q == HOLD);
    assign ir               = ir_q.ir;
    assign ir_pc            = ir_q.pc;
    assign pc_next          = ir_q.pc + 32'd4;
    assign opcode           = ir_q.ir[OPCODE_HI:OPCODE_LO];
    assign r_opcode         = ir_q.ir[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: zero-wait fetches, stalls,
// redirects in every state, PC wrap and mid-flight reset.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_rdata_valid;
    logic        inst_rdata_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] pc_next;
    logic [5:0]  opcode;
    logic [5:0]  r_opcode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .inst_addr        (inst_addr),
        .inst_req_valid   (inst_req_valid),
        .inst_req_ready   (inst_req_ready),
        .inst_rdata       (inst_rdata),
        .inst_rdata_valid (inst_rdata_valid),
        .inst_rdata_ready (inst_rdata_ready),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .ir_valid         (ir_valid),
        .ir_ready         (ir_ready),
        .ir               (ir),
        .ir_pc            (ir_pc),
        .pc_next          (pc_next),
        .opcode           (opcode),
        .r_opcode         (r_opcode)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"}, 32'(inst_req_valid), 32'd0);
        chk({tag, "_rdata_ready"}, 32'(inst_rdata_ready), 32'd0);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_ir"}, ir, 32'd0);
        chk({tag, "_ir_pc"}, ir_pc, 32'd0);
        chk({tag, "_addr"}, inst_addr, 32'd0);
        chk({tag, "_pc_next"}, pc_next, 32'd4);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_r_opcode"}, 32'(r_opcode), 32'd0);
    endtask

    // Called while in REQ; returns with the DUT in HOLD.
    task automatic fetch_zero(input logic [31:0] word);
        inst_req_ready = 1'b1;
        step();
        inst_req_ready   = 1'b0;
        inst_rdata       = word;
        inst_rdata_valid = 1'b1;
        step();
        inst_rdata_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        inst_req_ready   = 1'b0;
        inst_rdata       = 32'd0;
        inst_rdata_valid = 1'b0;
        redirect_valid   = 1'b0;
        redirect_target  = 32'd0;
        ir_ready         = 1'b0;
        step();
        step();
        chk_reset("rst");

        rst = 1'b0;
        step();
        chk("first_req_valid", 32'(inst_req_valid), 32'd1);
        chk("first_addr", inst_addr, 32'h0000_0000);
        t0 = cyc;
        fetch_zero(32'h2408_0005);
        chk("f0_ir_valid", 32'(ir_valid), 32'd1);
        chk("f0_latency", 32'(cyc - t0), 32'd2);
        chk("f0_ir", ir, 32'h2408_0005);
        chk("f0_opcode", 32'(opcode), 32'h09);
        chk("f0_r_opcode", 32'(r_opcode), 32'h05);
        chk("f0_pc_next", pc_next, 32'd4);

        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ir_valid", 32'(ir_valid), 32'd1);
            chk("stall_no_req", 32'(inst_req_valid), 32'd0);
            chk("stall_ir", ir, 32'h2408_0005);
        end

        ir_ready = 1'b1;
        step();
        chk("f1_addr", inst_addr, 32'h0000_0004);
        chk("f1_req_valid", 32'(inst_req_valid), 32'd1);
        t0 = cyc;
        fetch_zero(32'h0000_0020);
        chk("f1_ir_pc", ir_pc, 32'h0000_0004);
        chk("f1_r_opcode", 32'(r_opcode), 32'h20);
        step();
        chk("f2_addr", inst_addr, 32'h0000_0008);
        chk("f2_spacing", 32'(cyc - t0), 32'd3);

        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_req_valid", 32'(inst_req_valid), 32'd1);
            chk("bp_addr", inst_addr, 32'h0000_0008);
            chk("bp_no_wait", 32'(inst_rdata_ready), 32'd0);
        end
        fetch_zero(32'h8C01_0004);
        chk("f2_ir_pc", ir_pc, 32'h0000_0008);
        chk("f2_opcode", 32'(opcode), 32'h23);
        step();
        chk("f3_addr", inst_addr, 32'h0000_000C);

        inst_req_ready = 1'b1;
        step();
        inst_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("rw_still_wait", 32'(inst_rdata_ready), 32'd1);
        chk("rw_addr", inst_addr, 32'h0000_0100);
        step();
        inst_rdata       = 32'hDEAD_BEEF;
        inst_rdata_valid = 1'b1;
        step();
        inst_rdata_valid = 1'b0;
        chk("rw_dropped_valid", 32'(ir_valid), 32'd0);
        chk("rw_refetch", 32'(inst_req_valid), 32'd1);
        chk("rw_refetch_addr", inst_addr, 32'h0000_0100);
        chk("rw_ir_kept", ir, 32'h8C01_0004);

        ir_ready = 1'b0;
        fetch_zero(32'h0800_0040);
        chk("f4_ir_pc", ir_pc, 32'h0000_0100);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        ir_ready        = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("rh_ir_valid", 32'(ir_valid), 32'd0);
        chk("rh_addr", inst_addr, 32'hFFFF_FFFC);
        fetch_zero(32'h0000_0008);
        chk("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0000_0000);
        step();
        chk("wrap_addr", inst_addr, 32'h0000_0000);

        inst_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        step();
        inst_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("rq_wait", 32'(inst_rdata_ready), 32'd1);
        chk("rq_addr", inst_addr, 32'h0000_0200);
        inst_rdata       = 32'h1234_5678;
        inst_rdata_valid = 1'b1;
        step();
        inst_rdata_valid = 1'b0;
        chk("rq_dropped", 32'(ir_valid), 32'd0);
        chk("rq_refetch_addr", inst_addr, 32'h0000_0200);
        chk("rq_ir_kept", ir, 32'h0000_0008);

        inst_req_ready = 1'b1;
        step();
        inst_req_ready = 1'b0;
        chk("pre_rst_wait", 32'(inst_rdata_ready), 32'd1);
        rst = 1'b1;
        step();
        chk_reset("midrst");
        rst = 1'b0;
        step();
        chk("refetch_req", 32'(inst_req_valid), 32'd1);
        chk("refetch_addr", inst_addr, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
